multicycle_mem_bridge: RTL and testbench
========================================

Name: multicycle_mem_bridge

Overview:
Sits directly downstream of the multicycle control path. It turns its per-state memory strobes (mem_read_enable, mem_write_enable, data_format) into a request/ready bus transaction. It drives byte lanes and byte enables, sign/zero-extends load data, and returns mem_ready so the control FSM holds its current state until the access completes. A single bridge serves both instruction fetch and data access, since the control path already muxes the address.

Parameters:
TIMEOUT_CYCLES, 255, bus wait cycles tolerated before abort; range 1..65535; 16-bit counter.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
mem_read_enable  input  1  read strobe from control path; held until mem_ready
mem_write_enable  input  1  write strobe from control path; held until mem_ready
data_format  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
address  input  32  byte address (PC or ALU out, already muxed)
write_data  input  32  store data, right-aligned (rs2)
read_data  output  32  aligned, extended load result
mem_ready  output  1  one-cycle completion pulse
misaligned_fault  output  1  pulses with mem_ready on an illegal format or alignment
bus_timeout  output  1  pulses with mem_ready on watchdog expiry
bus_address  output  32  word address, address with bits [1:0] forced to 0
bus_read_request  output  1  bus read request
bus_write_request  output  1  bus write request
bus_byte_enable  output  4  active lanes
bus_write_data  output  32  lane-shifted store data
bus_read_data  input  32  raw word from bus
bus_ready  input  1  bus completes the access in the cycle it is high with a request

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE.
  - All outputs 0. Requests drop in the same cycle, including mid-transaction.
  - Captured registers and the watchdog counter cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Transition occurs when mem_write_enable or mem_read_enable is high.
  - Write has priority if both are high.
  - address, data_format, write_data and the direction are registered.
  - Legal access: next state BUSY.
  - Illegal access: next state DONE with the fault flag set; no bus request is issued.
- Illegal access is any of:
  - format 011, 110 or 111;
  - halfword with address[0]=1;
  - word with address[1:0]≠00.
- BUSY:
  - bus_*_request, bus_address, bus_byte_enable and bus_write_data are driven from registers and stay stable throughout BUSY.
  - Minimum latency: request visible 1 cycle after the enable is sampled.
  - bus_ready=1: latch extended read data (reads only), go to DONE.
  - bus_ready=0: increment counter. When the counter reaches TIMEOUT_CYCLES, drop the request and go to DONE with bus_timeout.
- DONE:
  - mem_ready=1 for exactly one cycle, with the flags valid in that cycle.
  - Next state is always IDLE. Enables that are still high in DONE are ignored, so there is no double issue.
  - The next access is sampled in the following IDLE cycle, so a fetch→load sequence is back-to-back with 1 idle cycle.
- Total access latency with 0 wait states: enable sampled at N, request at N+1, mem_ready at N+2.
- Byte enables and lanes (o = address[1:0]):
  - byte: 0001<<o, data replicated to all lanes;
  - half: 0011<<o, halfword replicated;
  - word: 1111.
- Load extension:
  - Select the byte or half at lane o.
  - B and H sign-extend; BU and HU zero-extend.
  - Write accesses and faults set read_data to 0.
- read_data holds its value until the next completion; it is updated only at entry to DONE.
- bus_ready seen while IDLE or DONE is ignored.

Decomposition:
- Shared package:
  - data_format codes (FMT_B/H/W/BU/HU), replacing magic 3'b010 uses;
  - bridge state enum;
  - byte-enable widths.
- Sub-module multicycle_load_align: combinational lane select and sign/zero extension. Inputs: raw word, offset, format. Output: 32-bit result. Reusable by a future single-cycle core.

Test Plan:
- Fetch, 0 wait: write-free read at address 0x100, format 010, bus_read_data=0xDEADBEEF → request at N+1, mem_ready at N+2, read_data=0xDEADBEEF, byte_enable=1111.
- LB with 3 waits: address 0x103, bus word 0x80FF_0000 → byte_enable=1000, request held for 4 cycles, read_data=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH: address 0x202, write_data=0x0000_ABCD → bus_address=0x200, byte_enable=1100, bus_write_data=0xABCDABCD, write request only.
- Misaligned LW: address 0x101 → no bus request, mem_ready + misaligned_fault pulse at N+1, read_data=0. Format 011 gives the same result.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held at 0 → request dropped after 4 BUSY cycles, bus_timeout + mem_ready for one cycle, then IDLE.
- Reset mid-BUSY: reset=0 asynchronously → bus_read_request falls without a clock edge. After release, a fresh access completes normally.

Source files
------------

// File: rtl/multicycle_mem_bridge_pkg.sv
// Shared definitions for the multicycle memory bridge: funct3 load/store codes,
// bridge states, byte-enable patterns and small lane helpers.
package multicycle_mem_bridge_pkg;

   localparam logic [2:0] FMT_B  = 3'b000;
   localparam logic [2:0] FMT_H  = 3'b001;
   localparam logic [2:0] FMT_W  = 3'b010;
   localparam logic [2:0] FMT_BU = 3'b100;
   localparam logic [2:0] FMT_HU = 3'b101;

   localparam int BE_W = 4;
   localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
   localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } bridge_state_e;

   // Unknown funct3 codes and unnaturally aligned halves/words never reach the bus.
   function automatic logic is_illegal(input logic [2:0] fmt, input logic [1:0] ofs);
      case (fmt)
         FMT_B, FMT_BU: is_illegal = 1'b0;
         FMT_H, FMT_HU: is_illegal = ofs[0];
         FMT_W:         is_illegal = (ofs != 2'b00);
         default:       is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] lane_enable(input logic [2:0] fmt, input logic [1:0] ofs);
      case (fmt)
         FMT_B, FMT_BU: lane_enable = BE_BYTE << ofs;
         FMT_H, FMT_HU: lane_enable = BE_HALF << ofs;
         default:       lane_enable = BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [2:0] fmt, input logic [31:0] data);
      case (fmt)
         FMT_B, FMT_BU: lane_data = {4{data[7:0]}};
         FMT_H, FMT_HU: lane_data = {2{data[15:0]}};
         default:       lane_data = data;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_mem_bridge_load_align.sv
// Combinational load alignment: picks the byte/half at the given lane offset
// and sign- or zero-extends it according to funct3.
module multicycle_load_align
   import multicycle_mem_bridge_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  format_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word_i >> {offset_i, 3'b000};
      case (format_i)
         FMT_B:   result_o = {{24{shifted[7]}}, shifted[7:0]};
         FMT_H:   result_o = {{16{shifted[15]}}, shifted[15:0]};
         FMT_BU:  result_o = {24'd0, shifted[7:0]};
         FMT_HU:  result_o = {16'd0, shifted[15:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/multicycle_mem_bridge.sv
// Converts held read/write strobes from the multicycle control path into a
// request/ready bus access, returning a one-cycle mem_ready pulse.
module multicycle_mem_bridge
   import multicycle_mem_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic [2:0]  data_format,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mem_ready,
   output logic        misaligned_fault,
   output logic        bus_timeout,
   output logic [31:0] bus_address,
   output logic        bus_read_request,
   output logic        bus_write_request,
   output logic [3:0]  bus_byte_enable,
   output logic [31:0] bus_write_data,
   input  logic [31:0] bus_read_data,
   input  logic        bus_ready
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   bridge_state_e state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [2:0]    fmt_q, fmt_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          write_q, write_d;
   logic          fault_q, fault_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [15:0]   count_q, count_d;
   logic [31:0]   aligned;
   logic          busy;

   multicycle_load_align u_align (
      .word_i   (bus_read_data),
      .offset_i (addr_q[1:0]),
      .format_i (fmt_q),
      .result_o (aligned)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         fmt_q     <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         fault_q   <= 1'b0;
         timeout_q <= 1'b0;
         rdata_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         fmt_q     <= fmt_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         fault_q   <= fault_d;
         timeout_q <= timeout_d;
         rdata_q   <= rdata_d;
         count_q   <= count_d;
      end
   end

   // read_data only changes on the transition into DONE; every other path holds it.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      fmt_d     = fmt_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      fault_d   = fault_q;
      timeout_d = timeout_q;
      rdata_d   = rdata_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_write_enable || mem_read_enable) begin
               addr_d    = address;
               fmt_d     = data_format;
               wdata_d   = write_data;
               write_d   = mem_write_enable;
               count_d   = '0;
               timeout_d = 1'b0;
               if (is_illegal(data_format, address[1:0])) begin
                  fault_d = 1'b1;
                  rdata_d = '0;
                  state_d = ST_DONE;
               end else begin
                  fault_d = 1'b0;
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (bus_ready) begin
               rdata_d = write_q ? 32'd0 : aligned;
               state_d = ST_DONE;
            end else if (count_q + 16'd1 == TIMEOUT_LIMIT) begin
               timeout_d = 1'b1;
               rdata_d   = '0;
               state_d   = ST_DONE;
            end else begin
               count_d = count_q + 16'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy              = (state_q == ST_BUSY);
   assign mem_ready         = (state_q == ST_DONE);
   assign misaligned_fault  = mem_ready && fault_q;
   assign bus_timeout       = mem_ready && timeout_q;
   assign read_data         = rdata_q;
   assign bus_read_request  = busy && !write_q;
   assign bus_write_request = busy && write_q;
   assign bus_address       = busy ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus_byte_enable   = busy ? lane_enable(fmt_q, addr_q[1:0]) : 4'd0;
   assign bus_write_data    = (busy && write_q) ? lane_data(fmt_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_multicycle_mem_bridge.sv
// Directed self-checking bench for multicycle_mem_bridge, run with a short
// watchdog so the timeout path is reachable in a few cycles.
module tb_multicycle_mem_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_read_enable = 1'b0;
   logic        mem_write_enable = 1'b0;
   logic [2:0]  data_format = 3'b000;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        mem_ready;
   logic        misaligned_fault;
   logic        bus_timeout;
   logic [31:0] bus_address;
   logic        bus_read_request;
   logic        bus_write_request;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data = 32'd0;
   logic        bus_ready = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;

   multicycle_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .mem_read_enable   (mem_read_enable),
      .mem_write_enable  (mem_write_enable),
      .data_format       (data_format),
      .address           (address),
      .write_data        (write_data),
      .read_data         (read_data),
      .mem_ready         (mem_ready),
      .misaligned_fault  (misaligned_fault),
      .bus_timeout       (bus_timeout),
      .bus_address       (bus_address),
      .bus_read_request  (bus_read_request),
      .bus_write_request (bus_write_request),
      .bus_byte_enable   (bus_byte_enable),
      .bus_write_data    (bus_write_data),
      .bus_read_data     (bus_read_data),
      .bus_ready         (bus_ready)
   );

   always #5 clock = ~clock;

   // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic re, input logic we, input logic [2:0] fmt,
                        input logic [31:0] addr, input logic [31:0] wdata);
      mem_read_enable  = re;
      mem_write_enable = we;
      data_format      = fmt;
      address          = addr;
      write_data       = wdata;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      tick();
      testsRun++;
      if ({mem_ready, misaligned_fault, bus_timeout, bus_read_request, bus_write_request} !== 5'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got %b expected 00000",
                  {mem_ready, misaligned_fault, bus_timeout, bus_read_request, bus_write_request});
      end
      testsRun++;
      if ({read_data, bus_address, bus_write_data, bus_byte_enable} !== 100'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_data: got rd=%h ba=%h wd=%h be=%b expected all zero",
                  read_data, bus_address, bus_write_data, bus_byte_enable);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      bus_ready = 1'b1;
      bus_read_data = 32'hDEADBEEF;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      tick();
      testsRun++;
      if ({bus_read_request, bus_write_request, mem_ready} !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL fetch_request: got rd/wr/rdy=%b expected 100",
                  {bus_read_request, bus_write_request, mem_ready});
      end
      testsRun++;
      if (bus_byte_enable !== 4'b1111 || bus_address !== 32'h100) begin
         testsFailed++;
         $display("[TB] FAIL fetch_bus: got be=%b addr=%h expected be=1111 addr=00000100",
                  bus_byte_enable, bus_address);
      end
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== 32'hDEADBEEF || bus_read_request !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL fetch_done: got rdy=%b rd=%h req=%b expected rdy=1 rd=deadbeef req=0",
                  mem_ready, read_data, bus_read_request);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      testsRun++;
      if (mem_ready !== 1'b0 || read_data !== 32'hDEADBEEF) begin
         testsFailed++;
         $display("[TB] FAIL fetch_hold: got rdy=%b rd=%h expected rdy=0 rd=deadbeef",
                  mem_ready, read_data);
      end
   endtask

   task automatic test_load_byte(input logic [2:0] fmt, input logic [31:0] expected, input string name);
      int held;
      held = 0;
      bus_ready = 1'b0;
      bus_read_data = 32'h80FF_0000;
      drive(1'b1, 1'b0, fmt, 32'h103, 32'd0);
      tick();
      testsRun++;
      if (bus_byte_enable !== 4'b1000 || bus_address !== 32'h100) begin
         testsFailed++;
         $display("[TB] FAIL %s_lanes: got be=%b addr=%h expected be=1000 addr=00000100",
                  name, bus_byte_enable, bus_address);
      end
      for (int i = 0; i < 4; i++) begin
         if (bus_read_request === 1'b1 && mem_ready === 1'b0) held++;
         if (i == 3) bus_ready = 1'b1;
         else tick();
      end
      testsRun++;
      if (held !== 4) begin
         testsFailed++;
         $display("[TB] FAIL %s_held: got %0d request cycles expected 4", name, held);
      end
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s_data: got rdy=%b rd=%h expected rdy=1 rd=%h",
                  name, mem_ready, read_data, expected);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_store(input logic [2:0] fmt, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] expAddr, input logic [3:0] expBe,
                             input logic [31:0] expData, input string name);
      bus_ready = 1'b1;
      drive(1'b0, 1'b1, fmt, addr, wdata);
      tick();
      testsRun++;
      if ({bus_write_request, bus_read_request} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL %s_request: got wr/rd=%b expected 10", name,
                  {bus_write_request, bus_read_request});
      end
      testsRun++;
      if (bus_address !== expAddr || bus_byte_enable !== expBe || bus_write_data !== expData) begin
         testsFailed++;
         $display("[TB] FAIL %s_bus: got addr=%h be=%b wd=%h expected addr=%h be=%b wd=%h",
                  name, bus_address, bus_byte_enable, bus_write_data, expAddr, expBe, expData);
      end
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL %s_done: got rdy=%b rd=%h expected rdy=1 rd=00000000",
                  name, mem_ready, read_data);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_misaligned(input logic [2:0] fmt, input logic [31:0] addr, input string name);
      bus_ready = 1'b1;
      bus_read_data = 32'h1234_5678;
      drive(1'b1, 1'b0, fmt, addr, 32'd0);
      tick();
      testsRun++;
      if ({mem_ready, misaligned_fault, bus_read_request, bus_write_request} !== 4'b1100
          || read_data !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL %s: got rdy/flt/rd/wr=%b rd=%h expected 1100 rd=00000000",
                  name, {mem_ready, misaligned_fault, bus_read_request, bus_write_request}, read_data);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      testsRun++;
      if ({mem_ready, misaligned_fault} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL %s_clear: got rdy/flt=%b expected 00", name, {mem_ready, misaligned_fault});
      end
   endtask

   task automatic test_timeout();
      int held;
      held = 0;
      bus_ready = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus_read_request === 1'b1 && mem_ready === 1'b0) held++;
      end
      testsRun++;
      if (held !== 4) begin
         testsFailed++;
         $display("[TB] FAIL timeout_held: got %0d request cycles expected 4", held);
      end
      tick();
      testsRun++;
      if ({mem_ready, bus_timeout, misaligned_fault, bus_read_request} !== 4'b1100) begin
         testsFailed++;
         $display("[TB] FAIL timeout_done: got rdy/to/flt/req=%b expected 1100",
                  {mem_ready, bus_timeout, misaligned_fault, bus_read_request});
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      testsRun++;
      if ({mem_ready, bus_timeout, bus_read_request} !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL timeout_idle: got rdy/to/req=%b expected 000",
                  {mem_ready, bus_timeout, bus_read_request});
      end
   endtask

   task automatic test_back_to_back();
      bus_ready = 1'b1;
      bus_read_data = 32'h8001_0000;
      drive(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
      tick();
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== 32'h8001_0000) begin
         testsFailed++;
         $display("[TB] FAIL b2b_first: got rdy=%b rd=%h expected rdy=1 rd=80010000",
                  mem_ready, read_data);
      end
      tick();
      testsRun++;
      if ({bus_read_request, mem_ready} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL b2b_no_double: got req/rdy=%b expected 00", {bus_read_request, mem_ready});
      end
      drive(1'b1, 1'b0, 3'b001, 32'h206, 32'd0);
      tick();
      testsRun++;
      if (bus_read_request !== 1'b1 || bus_byte_enable !== 4'b1100) begin
         testsFailed++;
         $display("[TB] FAIL b2b_second_req: got req=%b be=%b expected req=1 be=1100",
                  bus_read_request, bus_byte_enable);
      end
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== 32'hFFFF_8001) begin
         testsFailed++;
         $display("[TB] FAIL b2b_second_data: got rdy=%b rd=%h expected rdy=1 rd=ffff8001",
                  mem_ready, read_data);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_reset_mid_busy();
      bus_ready = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
      tick();
      testsRun++;
      if (bus_read_request !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL midreset_pre: got req=%b expected 1", bus_read_request);
      end
      #1 reset = 1'b0;
      #1;
      testsRun++;
      if ({bus_read_request, mem_ready} !== 2'b00 || read_data !== 32'd0 || bus_address !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_async: got req=%b rdy=%b rd=%h ba=%h expected all zero",
                  bus_read_request, mem_ready, read_data, bus_address);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      #2 reset = 1'b1;
      tick();
      bus_ready = 1'b1;
      bus_read_data = 32'hCAFE_F00D;
      drive(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
      tick();
      tick();
      testsRun++;
      if (mem_ready !== 1'b1 || read_data !== 32'hCAFE_F00D) begin
         testsFailed++;
         $display("[TB] FAIL midreset_after: got rdy=%b rd=%h expected rdy=1 rd=cafef00d",
                  mem_ready, read_data);
      end
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
      test_load_byte(3'b100, 32'h0000_0080, "lbu");
      test_store(3'b001, 32'h202, 32'h0000_ABCD, 32'h200, 4'b1100, 32'hABCD_ABCD, "sh");
      test_store(3'b000, 32'h201, 32'h1234_5678, 32'h200, 4'b0010, 32'h7878_7878, "sb");
      test_misaligned(3'b010, 32'h101, "lw_misaligned");
      test_misaligned(3'b011, 32'h100, "fmt_011");
      test_misaligned(3'b001, 32'h103, "lh_misaligned");
      test_timeout();
      test_back_to_back();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
